// File: rtl/mac_drain_requant.sv
// mac_drain_requant
// Drains one tile of results from a row of free-running PE_MAC accumulators,
// turns the running sums into per-tile sums by differencing against the
// previous capture, requantizes each column to WIDTH bits and streams the
// columns out over a valid/ready interface.
//
// Ports
//   clk      clock, rising edge
//   rstn     asynchronous active-low reset, shared with the upstream PEs
//   i_start  begin one tile (only looked at in IDLE)
//   i_k      accumulation cycles of the tile, taken with i_start
//   i_shift  requant right shift, taken with i_start
//   i_mac    packed PE accumulators, column j at [j*2*WIDTH +: 2*WIDTH]
//   o_valid  o_data/o_idx/o_last valid
//   i_ready  downstream accepts the beat when o_valid && i_ready
//   o_data   requantized, saturated column result
//   o_idx    column index of o_data
//   o_last   marks the column N-1 beat
//   o_busy   high whenever a tile is in flight (any state but IDLE)
//   o_done   single-cycle pulse after the last beat
module mac_drain_requant #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_start,
    input  logic [15:0]            i_k,
    input  logic [3:0]             i_shift,
    input  logic [N*2*WIDTH-1:0]   i_mac,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(N)-1:0]   o_idx,
    output logic                   o_last,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int AW = 2 * WIDTH;
    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_CAPTURE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [16:0]     r_cnt;
    logic [3:0]      r_shift;
    logic [IW-1:0]   r_idx;
    logic [AW-1:0]   r_delta [N];
    logic [AW-1:0]   r_base  [N];

    logic [AW-1:0]   w_mac      [N];
    logic [AW-1:0]   w_capDelta [N];
    logic [IW-1:0]   w_nextIdx;
    logic            w_lastIdx;

    // Round-half-up right shift followed by unsigned saturation. The sum is
    // carried one bit wider than the accumulator so the rounding add can
    // never wrap a large delta back to a small value.
    function automatic logic [WIDTH-1:0] requant(input logic [AW-1:0] d,
                                                 input logic [3:0]    sh);
        logic [AW:0] rnd;
        logic [AW:0] sum;
        logic [AW:0] r;
        rnd = '0;
        if (sh != 4'd0) begin
            rnd = (AW+1)'(1) << (sh - 4'd1);
        end
        sum = {1'b0, d} + rnd;
        r   = sum >> sh;
        if (|r[AW:WIDTH]) begin
            return '1;
        end
        return r[WIDTH-1:0];
    endfunction

    // Unpack the accumulator bus and form the per-tile sums. The PEs never
    // clear, so subtracting the previous capture (modulo 2^AW) recovers the
    // contribution of this tile even across accumulator wrap.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_mac[j]      = i_mac[j*AW +: AW];
            w_capDelta[j] = w_mac[j] - r_base[j];
        end
    end

    assign w_nextIdx = r_idx + IW'(1);
    assign w_lastIdx = (r_idx == IW'(N - 1));

    // Tile sequencer. All outputs are registered; the next beat is
    // requantized on the handshake edge so o_data is ready when o_valid is.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_idx   <= '0;
            for (int j = 0; j < N; j++) begin
                r_delta[j] <= '0;
                r_base[j]  <= '0;
            end
            o_valid <= 1'b0;
            o_data  <= '0;
            o_idx   <= '0;
            o_last  <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        // LAT >= 1 keeps the load non-zero even for i_k == 0.
                        r_cnt   <= {1'b0, i_k} + 17'(LAT);
                        r_shift <= i_shift;
                        o_busy  <= 1'b1;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_cnt <= r_cnt - 17'd1;
                    if (r_cnt == 17'd1) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    for (int j = 0; j < N; j++) begin
                        r_delta[j] <= w_capDelta[j];
                        r_base[j]  <= w_mac[j];
                    end
                    r_idx   <= '0;
                    o_idx   <= '0;
                    o_data  <= requant(w_capDelta[0], r_shift);
                    o_last  <= 1'(N == 1);
                    o_valid <= 1'b1;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (i_ready) begin
                        if (w_lastIdx) begin
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            o_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx  <= w_nextIdx;
                            o_idx  <= w_nextIdx;
                            o_data <= requant(r_delta[w_nextIdx], r_shift);
                            o_last <= (w_nextIdx == IW'(N - 1));
                        end
                    end
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
